code_class_tracker: RTL and testbench

CODE_CLASS_TRACKER -- requirements
Module: code_class_tracker

---
 rtl/code_class_pkg.sv | 37 +++
 rtl/sat_counter.sv | 25 ++
 rtl/code_class_tracker.sv | 114 +++++++++++
 tb/tb_code_class_tracker.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/code_class_pkg.sv
// Shared code constants, FSM state and class decode for the code class tracker.
package code_class_pkg;

  localparam int unsigned CODE_W  = 8;
  localparam int unsigned TIMER_W = 8;

  localparam logic [CODE_W-1:0] CODE_A = 8'h40;
  localparam logic [CODE_W-1:0] CODE_B = 8'h20;
  localparam logic [CODE_W-1:0] CODE_D = 8'h04;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GOT_A = 1'b1
  } state_e;

  // One-hot class of an accepted code; err covers every unlisted value.
  typedef struct packed {
    logic a;
    logic b;
    logic d;
    logic err;
  } class_hit_t;

  // Map a raw code onto exactly one class flag.
  function automatic class_hit_t decode_class(input logic [CODE_W-1:0] code);
    class_hit_t cls;
    cls = '0;
    case (code)
      CODE_A:  cls.a   = 1'b1;
      CODE_B:  cls.b   = 1'b1;
      CODE_D:  cls.d   = 1'b1;
      default: cls.err = 1'b1;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX = '1;

  // Count register: clear wins over increment, increment stops at MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != MAX)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/code_class_tracker.sv
// Counts accepted codes per class and flags class-A followed by class-B within a window.
module code_class_tracker
  import code_class_pkg::*;
#(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned WINDOW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b,
  output logic [CNT_W-1:0]  cnt_d,
  output logic [CNT_W-1:0]  cnt_err,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic              seq_hit
);

  localparam logic [TIMER_W-1:0] WIN = TIMER_W'(WINDOW);

  state_e             state;
  state_e             state_nxt;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_nxt;
  logic               hit_c;
  logic               xfer_c;
  class_hit_t         cls_c;

  assign in_ready = !clr;
  assign xfer_c   = in_valid && in_ready;
  assign cls_c    = decode_class(in_code);

  // State, window timer and registered hit pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      timer   <= '0;
      seq_hit <= 1'b0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      seq_hit <= hit_c;
    end
  end

  // Next state: A arms the window, B or any other code disarms, expiry disarms.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (xfer_c && cls_c.a) state_nxt = ST_GOT_A;
      end
      ST_GOT_A: begin
        if (xfer_c) begin
          state_nxt = cls_c.a ? ST_GOT_A : ST_IDLE;
        end else if (timer == '0) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (clr) state_nxt = ST_IDLE;
  end

  // Timer reload/decrement and hit detection.
  always_comb begin
    timer_nxt = timer;
    hit_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        timer_nxt = (xfer_c && cls_c.a) ? WIN : '0;
      end
      ST_GOT_A: begin
        if (xfer_c) begin
          if (cls_c.a) begin
            timer_nxt = WIN;
          end else begin
            timer_nxt = '0;
            hit_c     = cls_c.b;
          end
        end else if (timer != '0) begin
          timer_nxt = timer - TIMER_W'(1);
        end else begin
          timer_nxt = '0;
        end
      end
      default: timer_nxt = '0;
    endcase
    if (clr) begin
      timer_nxt = '0;
      hit_c     = 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(xfer_c && cls_c.a), .q(cnt_a)
  );
  sat_counter #(.W(CNT_W)) u_cnt_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(xfer_c && cls_c.b), .q(cnt_b)
  );
  sat_counter #(.W(CNT_W)) u_cnt_d (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(xfer_c && cls_c.d), .q(cnt_d)
  );
  sat_counter #(.W(CNT_W)) u_cnt_err (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(xfer_c && cls_c.err), .q(cnt_err)
  );
  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(hit_c), .q(hit_cnt)
  );

endmodule

// File: tb/tb_code_class_tracker.sv
// Directed bench for code_class_tracker with a queue of expected hit pulses.
module tb_code_class_tracker;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WINDOW = 8;

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_code;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_err;
  logic [CNT_W-1:0] hit_cnt;
  logic             seq_hit;

  int checks   = 0;
  int failures = 0;
  bit exp_q[$];

  code_class_tracker #(.CNT_W(CNT_W), .WINDOW(WINDOW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_d(cnt_d),
    .cnt_err(cnt_err), .hit_cnt(hit_cnt), .seq_hit(seq_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkc(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_counts(input string tag, input int a, input int b, input int d,
                            input int e, input int h);
    chkc({tag, ".cnt_a"},   cnt_a,   CNT_W'(a));
    chkc({tag, ".cnt_b"},   cnt_b,   CNT_W'(b));
    chkc({tag, ".cnt_d"},   cnt_d,   CNT_W'(d));
    chkc({tag, ".cnt_err"}, cnt_err, CNT_W'(e));
    chkc({tag, ".hit_cnt"}, hit_cnt, CNT_W'(h));
  endtask

  // One clock of stimulus; exp_hit is seq_hit just after this edge.
  task automatic step(input logic v, input logic [7:0] code, input logic c, input bit exp_hit);
    bit e;
    @(negedge clk);
    in_valid = v;
    in_code  = code;
    clr      = c;
    exp_q.push_back(exp_hit);
    #1;
    chk1("in_ready", in_ready, !c);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      chk1("seq_hit", seq_hit, e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n    = 1'b0;
    clr      = 1'b0;
    in_valid = 1'b0;
    in_code  = 8'h00;

    // Reset state, before any clock edge
    #1;
    chk_counts("reset", 0, 0, 0, 0, 0);
    chk1("reset.seq_hit", seq_hit, 1'b0);
    chk1("reset.in_ready", in_ready, 1'b1);
    clr = 1'b1;
    #1;
    chk1("reset.in_ready_clr", in_ready, 1'b0);
    clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Basic classification with back-to-back transfers
    step(1'b1, 8'h40, 1'b0, 1'b0);
    step(1'b1, 8'h20, 1'b0, 1'b1);
    step(1'b1, 8'h04, 1'b0, 1'b0);
    step(1'b1, 8'h2a, 1'b0, 1'b0);
    idle(1);
    chk_counts("basic", 1, 1, 1, 1, 1);

    // Window boundary: WINDOW idles hits, WINDOW+1 does not
    step(1'b1, 8'h40, 1'b0, 1'b0);
    idle(WINDOW);
    step(1'b1, 8'h20, 1'b0, 1'b1);
    idle(1);
    step(1'b1, 8'h40, 1'b0, 1'b0);
    idle(WINDOW + 1);
    step(1'b1, 8'h20, 1'b0, 1'b0);
    idle(1);
    chk_counts("window", 3, 3, 1, 1, 2);

    // Repeated A, interrupted and uninterrupted
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk_counts("clr1", 0, 0, 0, 0, 0);
    step(1'b1, 8'h40, 1'b0, 1'b0);
    step(1'b1, 8'h40, 1'b0, 1'b0);
    step(1'b1, 8'h04, 1'b0, 1'b0);
    step(1'b1, 8'h20, 1'b0, 1'b0);
    step(1'b1, 8'h40, 1'b0, 1'b0);
    step(1'b1, 8'h40, 1'b0, 1'b0);
    step(1'b1, 8'h20, 1'b0, 1'b1);
    idle(1);
    chk_counts("repeatA", 4, 2, 1, 0, 1);

    // Saturation at 2^CNT_W-1
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b1, 8'h04, 1'b0, 1'b0);
    chkc("sat.cnt_d_15", cnt_d, 4'd15);
    for (int i = 0; i < 5; i++) step(1'b1, 8'h04, 1'b0, 1'b0);
    idle(1);
    chk_counts("sat", 0, 0, 15, 0, 0);

    // Clear blocks a simultaneous transfer
    step(1'b1, 8'h40, 1'b1, 1'b0);
    chk_counts("clr_xfer", 0, 0, 0, 0, 0);
    step(1'b1, 8'h20, 1'b0, 1'b0);
    idle(1);
    chk_counts("clr_after", 0, 1, 0, 0, 0);

    // Clear while armed discards the pending A
    step(1'b1, 8'h40, 1'b0, 1'b0);
    step(1'b1, 8'h20, 1'b1, 1'b0);
    step(1'b1, 8'h20, 1'b0, 1'b0);
    idle(1);
    chk_counts("clr_armed", 0, 1, 0, 0, 0);

    // Asynchronous reset while armed
    step(1'b1, 8'h40, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_counts("async_rst", 0, 0, 0, 0, 0);
    chk1("async_rst.seq_hit", seq_hit, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h20, 1'b0, 1'b0);
    idle(1);
    chk_counts("post_rst", 0, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
